// File: rtl/pad_cfg_sequencer.sv
// Padring cfg/oen owner: shadow regs over req/gnt port (1-cycle response, never stalls),
// commit runs freeze -> apply -> settle with all pads forced input-only until release.
module pad_cfg_sequencer #(
    parameter int              NPADS         = 9,
    parameter int              CFGW          = 8,
    parameter int              SETTLE_CYCLES = 16,
    parameter logic [CFGW-1:0] CFG_RESET     = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [5:0]                 addr_i,
    input  logic [CFGW-1:0]            wdata_i,
    output logic                       gnt_o,
    output logic                       rvalid_o,
    output logic [CFGW-1:0]            rdata_o,
    output logic                       err_o,
    input  logic                       commit_i,
    output logic                       busy_o,
    input  logic [4*NPADS-1:0]         oen_i,
    output logic [4*NPADS-1:0]         oen_o,
    output logic [4*NPADS*CFGW-1:0]    cfg_o
);
    localparam int NENT = 4 * NPADS;
    localparam int CW   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FREEZE = 2'd1;
    localparam logic [1:0] S_APPLY  = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pending;
    logic [CFGW-1:0] r_shadow [NENT];
    logic [CFGW-1:0] r_active [NENT];
    logic            r_rvalid;
    logic            r_err;
    logic [CFGW-1:0] r_rdata;

    logic            w_valid_pad;
    logic [6:0]      w_flat;
    logic            w_wr;
    logic [CFGW-1:0] w_rd_dat;

    assign w_valid_pad = (addr_i[3:0] < 4'(NPADS));
    assign w_flat      = 7'(addr_i[5:4]) * 7'(NPADS) + 7'(addr_i[3:0]);
    assign w_wr        = req_i & we_i & w_valid_pad;

    always_comb begin
        w_rd_dat = '0;
        for (int i = 0; i < NENT; i++) begin
            if (w_flat == 7'(i)) w_rd_dat = r_shadow[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NENT; i++) r_shadow[i] <= CFG_RESET;
        end else begin
            for (int i = 0; i < NENT; i++) begin
                if (w_wr && (w_flat == 7'(i))) r_shadow[i] <= wdata_i;
            end
        end
    end

    // Whole array copied in one edge so the padring never sees a partial update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NENT; i++) r_active[i] <= CFG_RESET;
        end else if (r_state == S_APPLY) begin
            for (int i = 0; i < NENT; i++) r_active[i] <= r_shadow[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_err    <= req_i & ~w_valid_pad;
            r_rdata  <= (req_i && !we_i && w_valid_pad) ? w_rd_dat : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_SETTLE;
            r_cnt     <= CNT_LOAD;
            r_pending <= 1'b0;
        end else begin
            // Commits seen mid-sequence collapse into one deferred restart.
            r_pending <= (r_state != S_IDLE) ? (r_pending | commit_i) : 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (commit_i || r_pending) begin
                        r_state <= S_FREEZE;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_FREEZE: begin
                    if (r_cnt == '0) r_state <= S_APPLY;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_APPLY: begin
                    r_state <= S_SETTLE;
                    r_cnt   <= CNT_LOAD;
                end
                S_SETTLE: begin
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt_o    = req_i;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign busy_o   = (r_state != S_IDLE);
    assign oen_o    = (r_state == S_IDLE) ? oen_i : '1;

    for (genvar g = 0; g < NENT; g++) begin : g_cfg
        assign cfg_o[g*CFGW +: CFGW] = r_active[g];
    end
endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer with immediate-assertion checks.
module tb_pad_cfg_sequencer;
    localparam int NPADS = 9;
    localparam int CFGW  = 8;
    localparam logic [35:0] ALL1 = {36{1'b1}};
    localparam logic [35:0] OEN_PAT = 36'h0_0000_00FF;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic [5:0]   addr_i;
    logic [7:0]   wdata_i;
    logic         gnt_o;
    logic         rvalid_o;
    logic [7:0]   rdata_o;
    logic         err_o;
    logic         commit_i;
    logic         busy_o;
    logic [35:0]  oen_i;
    logic [35:0]  oen_o;
    logic [287:0] cfg_o;

    int checks = 0;
    int errors = 0;

    pad_cfg_sequencer #(.NPADS(NPADS), .CFGW(CFGW), .SETTLE_CYCLES(16), .CFG_RESET(8'h00)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .commit_i(commit_i), .busy_o(busy_o), .oen_i(oen_i),
        .oen_o(oen_o), .cfg_o(cfg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] field(input int k);
        return cfg_o[k*8 +: 8];
    endfunction

    task automatic access(input logic w, input logic [5:0] a, input logic [7:0] d);
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        #1;
        chk("gnt", 64'(gnt_o), 64'd1);
        tick();
        req_i = 1'b0; we_i = 1'b0;
    endtask

    // Ticks until busy_o drops (bounded); returns ticks taken and count of unforced-oen cycles.
    task automatic wait_idle(output int n, output int viol);
        n = 0; viol = 0;
        while (busy_o && n < 200) begin
            if (oen_o !== ALL1) viol++;
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int viol;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        commit_i = 1'b0; oen_i = OEN_PAT;
        tick(); tick();

        chk("rst_busy",   64'(busy_o),   64'd1);
        chk("rst_oen",    64'(oen_o),    64'(ALL1));
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rdata",  64'(rdata_o),  64'd0);
        chk("rst_err",    64'(err_o),    64'd0);
        chk("rst_cfg0",   64'(cfg_o == '0), 64'd1);

        rst_i = 1'b0;
        wait_idle(n, viol);
        chk("rst_settle_len", 64'(n), 64'd16);
        chk("rst_settle_oen", 64'(viol), 64'd0);
        chk("idle_oen_pass", 64'(oen_o), 64'(OEN_PAT));

        // Write/read side1 pad3 (flat field 12)
        access(1'b1, 6'h13, 8'hA5);
        chk("wr_rvalid", 64'(rvalid_o), 64'd1);
        chk("wr_err",    64'(err_o),    64'd0);
        access(1'b0, 6'h13, 8'h00);
        chk("rd_rvalid", 64'(rvalid_o), 64'd1);
        chk("rd_rdata",  64'(rdata_o),  64'hA5);
        chk("rd_err",    64'(err_o),    64'd0);
        chk("cfg12_pre", 64'(field(12)), 64'h00);
        tick();
        chk("rvalid_1cyc", 64'(rvalid_o), 64'd0);

        // Commit: 33 busy cycles, apply on 17th edge after commit
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        n = 0; viol = 0;
        while (busy_o && n < 200) begin
            if (oen_o !== ALL1) viol++;
            tick();
            n++;
            if (n == 16) chk("cfg12_before_apply", 64'(field(12)), 64'h00);
            if (n == 17) chk("cfg12_at_apply", 64'(field(12)), 64'hA5);
        end
        chk("commit_busy_len", 64'(n), 64'd33);
        chk("commit_oen_forced", 64'(viol), 64'd0);
        chk("commit_oen_release", 64'(oen_o), 64'(OEN_PAT));
        chk("cfg12_post", 64'(field(12)), 64'hA5);

        // Out-of-range pad 12 on side 0 (flat 12 would alias side1 pad3)
        access(1'b1, 6'h0C, 8'hFF);
        chk("oob_wr_err", 64'(err_o), 64'd1);
        access(1'b0, 6'h0C, 8'h00);
        chk("oob_rd_err",   64'(err_o),   64'd1);
        chk("oob_rd_rdata", 64'(rdata_o), 64'h00);
        access(1'b0, 6'h13, 8'h00);
        chk("oob_no_alias", 64'(rdata_o), 64'hA5);
        access(1'b0, 6'h03, 8'h00);
        chk("oob_side0_p3", 64'(rdata_o), 64'h00);

        // Commit, then write + commit during SETTLE -> deferred second sequence
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        chk("in_settle_busy", 64'(busy_o), 64'd1);
        access(1'b1, 6'h38, 8'h3C);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        wait_idle(n, viol);
        chk("seq1_oen_forced", 64'(viol), 64'd0);
        chk("cfg35_not_yet", 64'(field(35)), 64'h00);
        chk("idle_gap_oen", 64'(oen_o), 64'(OEN_PAT));
        tick();
        chk("seq2_started", 64'(busy_o), 64'd1);
        wait_idle(n, viol);
        chk("seq2_busy_len", 64'(n), 64'd33);
        chk("seq2_oen_forced", 64'(viol), 64'd0);
        chk("cfg35_applied", 64'(field(35)), 64'h3C);
        chk("cfg12_kept", 64'(field(12)), 64'hA5);
        tick(); tick();
        chk("no_extra_seq", 64'(busy_o), 64'd0);

        // Reset during FREEZE
        access(1'b1, 6'h00, 8'hFF);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        req_i = 1'b1; we_i = 1'b0; addr_i = 6'h13;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_busy",   64'(busy_o),   64'd1);
        chk("arst_oen",    64'(oen_o),    64'(ALL1));
        chk("arst_cfg",    64'(cfg_o == '0), 64'd1);
        chk("arst_rvalid", 64'(rvalid_o), 64'd0);
        req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        access(1'b0, 6'h00, 8'h00);
        chk("post_rst_rvalid", 64'(rvalid_o), 64'd1);
        chk("post_rst_rd0", 64'(rdata_o), 64'h00);
        access(1'b0, 6'h13, 8'h00);
        chk("post_rst_rd13", 64'(rdata_o), 64'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
